// File: rtl/ppu_frame_ctrl.sv
// PPU frame-buffer controller: sequences VRAM copy (SYNC), display (DISP) and
// late-CPU (LATE) phases, rotating display/CPU buffer indices once per frame.
module ppu_frame_ctrl #(
  parameter  int unsigned NUM_BUF    = 2,
  parameter  int unsigned IRQ_DELAY  = 1,
  parameter  int unsigned LATE_CNT_W = 8,
  localparam int unsigned BUF_W      = (NUM_BUF > 2) ? $clog2(NUM_BUF) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vblank_start,
  input  logic                  vblank_end,
  input  logic                  rowram_swap,
  input  logic                  cpu_wr_busy,
  input  logic                  sync_done,
  input  logic                  late_cnt_clr,
  output logic                  sync_start,
  output logic                  sync_active,
  output logic                  rowram_swap_disp,
  output logic                  cpu_vram_wr_irq,
  output logic [BUF_W-1:0]      disp_buf,
  output logic [BUF_W-1:0]      cpu_buf,
  output logic [LATE_CNT_W-1:0] late_cnt,
  output logic                  sync_err
);

  typedef enum logic [1:0] {SYNC, DISP, LATE} state_e;

  localparam logic [LATE_CNT_W-1:0] LATE_MAX = '1;
  localparam logic [BUF_W-1:0]      BUF_LAST = BUF_W'(NUM_BUF - 1);
  localparam logic [3:0]            IRQ_LOAD = 4'(IRQ_DELAY);

  state_e                  state_q, state_d;
  logic                    sync_start_q, sync_start_d;
  logic                    start_pend_q, start_pend_d;
  logic                    copy_ok_q, copy_ok_d;
  logic                    irq_q, irq_d;
  logic                    irq_act_q, irq_act_d;
  logic [3:0]              irq_cnt_q, irq_cnt_d;
  logic [BUF_W-1:0]        disp_buf_q, disp_buf_d;
  logic [BUF_W-1:0]        cpu_buf_q, cpu_buf_d;
  logic [LATE_CNT_W-1:0]   late_cnt_q, late_cnt_d;
  logic                    sync_err_q, sync_err_d;
  logic                    late_inc;

  always_comb begin
    state_d      = state_q;
    sync_start_d = 1'b0;
    start_pend_d = start_pend_q;
    copy_ok_d    = copy_ok_q;
    disp_buf_d   = disp_buf_q;
    cpu_buf_d    = cpu_buf_q;
    sync_err_d   = sync_err_q;
    late_inc     = 1'b0;
    late_cnt_d   = late_cnt_q;
    irq_d        = 1'b0;
    irq_act_d    = irq_act_q;
    irq_cnt_d    = irq_cnt_q;

    // Reset leaves SYNC already entered; the initial copy launches one cycle later.
    if (start_pend_q) begin
      sync_start_d = 1'b1;
      start_pend_d = 1'b0;
    end

    unique case (state_q)
      SYNC: begin
        if (vblank_end && !vblank_start) begin
          state_d = DISP;
          if (!copy_ok_q) sync_err_d = 1'b1;
        end else if (sync_done) begin
          copy_ok_d = 1'b1;
        end
      end
      DISP: begin
        if (vblank_start) begin
          if (cpu_wr_busy) begin
            state_d  = LATE;
            late_inc = 1'b1;
          end else begin
            state_d      = SYNC;
            sync_start_d = 1'b1;
            copy_ok_d    = 1'b0;
            disp_buf_d   = cpu_buf_q;
            cpu_buf_d    = (cpu_buf_q == BUF_LAST) ? '0 : cpu_buf_q + 1'b1;
          end
        end
      end
      LATE: begin
        if (vblank_end && !vblank_start) begin
          if (cpu_wr_busy) late_inc = 1'b1;
          else             state_d  = DISP;
        end
      end
      default: state_d = SYNC;
    endcase

    if (late_cnt_clr)
      late_cnt_d = '0;
    else if (late_inc && (late_cnt_q != LATE_MAX))
      late_cnt_d = late_cnt_q + 1'b1;

    // IRQ timer: armed on DISP entry, cancelled by any exit before it fires.
    if (state_d != DISP) begin
      irq_act_d = 1'b0;
    end else if (state_q != DISP) begin
      if (IRQ_DELAY == 0) begin
        irq_d = 1'b1;
      end else begin
        irq_act_d = 1'b1;
        irq_cnt_d = IRQ_LOAD;
      end
    end else if (irq_act_q) begin
      if (irq_cnt_q == 4'd1) begin
        irq_d     = 1'b1;
        irq_act_d = 1'b0;
      end else begin
        irq_cnt_d = irq_cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      sync_start_q <= 1'b0;
      start_pend_q <= 1'b1;
      copy_ok_q    <= 1'b0;
      irq_q        <= 1'b0;
      irq_act_q    <= 1'b0;
      irq_cnt_q    <= '0;
      disp_buf_q   <= '0;
      cpu_buf_q    <= BUF_W'(1);
      late_cnt_q   <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_start_q <= sync_start_d;
      start_pend_q <= start_pend_d;
      copy_ok_q    <= copy_ok_d;
      irq_q        <= irq_d;
      irq_act_q    <= irq_act_d;
      irq_cnt_q    <= irq_cnt_d;
      disp_buf_q   <= disp_buf_d;
      cpu_buf_q    <= cpu_buf_d;
      late_cnt_q   <= late_cnt_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign sync_start       = sync_start_q;
  assign sync_active      = (state_q == SYNC);
  assign rowram_swap_disp = (state_q == DISP) && rowram_swap;
  assign cpu_vram_wr_irq  = irq_q;
  assign disp_buf         = disp_buf_q;
  assign cpu_buf          = cpu_buf_q;
  assign late_cnt         = late_cnt_q;
  assign sync_err         = sync_err_q;

endmodule
